multi_bay_parking_meter: RTL and testbench
==========================================

Name: multi_bay_parking_meter

Overview:
- Parametrised successor to the single-space meter: one controller serves NUM_BAYS independent parking bays, each with its own countdown in seconds.
- Coin and preset pulses are applied to the bay chosen by `bay_sel`.
- All bays decrement from one shared, free-running seconds tick.
- The selected bay's remaining time is shown as BCD and on a multiplexed 4-digit 7-segment display, with per-state blink modes. Per-bay expired and low-time flags go to the enforcement/status logic.

Parameters:
- CLK_HZ, 100: clk frequency; prescaler terminal count is CLK_HZ-1.
- NUM_BAYS, 4: number of bays, 1..16; SEL_W = max(1, clog2(NUM_BAYS)).
- MAX_TIME, 9999: saturation ceiling in seconds, ≤ 9999; CNT_W = clog2(MAX_TIME+1).
- ADD0..ADD3, 60/120/180/300: seconds added by add[0]..add[3].
- PRESET_LO, 16: value loaded by preset_lo.
- PRESET_HI, 150: value loaded by preset_hi.
- LOW_THRESH, 180: counts below this value (and nonzero) are the low-time state.
- SCAN_DIV, 1: clocks per display digit slot.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bay_sel  in  SEL_W  target bay for add/preset, and the displayed bay; values ≥ NUM_BAYS are ignored for add/preset and display blank
- add  in  4  single-cycle coin pulses
- preset_lo  in  1  load PRESET_LO into the selected bay
- preset_hi  in  1  load PRESET_HI into the selected bay
- val  out  16  {thousands, hundreds, tens, ones} BCD of the selected bay
- led_seg  out  7  active-low segments {a..g}
- an  out  4  active-low digit enables, an[3] = thousands
- expired  out  NUM_BAYS  bit i = (count[i] == 0)
- low_time  out  NUM_BAYS  bit i = (0 < count[i] < LOW_THRESH)

Behaviour:
- Reset (synchronous, active-high), values after the first rising edge with rst=1:
  - all count[i] = 0, prescaler = 0, scan index = 0
  - val = 0, an = 4'hF, led_seg = 7'h7F
  - expired = all ones, low_time = 0
- Prescaler:
  - Free-running 0..CLK_HZ-1. `tick` is asserted in the cycle where it equals CLK_HZ-1.
  - It is NOT cleared by key activity. This is a deliberate change so that one bay's coin does not stretch every other bay's second.
- Per-bay update each cycle, applied only to bay i = bay_sel when bay_sel < NUM_BAYS. Priority: preset_lo > preset_hi > add[3] > add[2] > add[1] > add[0].
  - Preset: count loads the preset value.
  - Add: count = min(count + ADDk, MAX_TIME). Compute the sum in CNT_W+1 bits.
  - Only one action per cycle; lower-priority pulses in the same cycle are discarded.
  - If an action hits bay i in a tick cycle, the action wins and bay i skips that decrement. Other bays still decrement.
- Decrement: on tick, every bay not being written decrements if nonzero. A bay at 0 stays at 0 (no wrap).
- Flags: expired and low_time are combinational from the count registers, so they are valid in the same cycle the count updates.
- BCD:
  - val is a registered conversion of count[bay_sel], with 1-cycle latency.
  - A bay_sel change is reflected on val after 1 cycle.
  - Out-of-range bay_sel gives val = 0.
- Display state of the selected bay, from the registered val source:
  - IDLE (count = 0): blink at 1 Hz, 50% duty. Digits are blanked while prescaler ≥ CLK_HZ/2 and shown otherwise.
  - LOW (0 < count < LOW_THRESH): blink at 0.5 Hz. Digits are shown when count[0] = 0 and blanked when count[0] = 1.
  - HIGH (count ≥ LOW_THRESH): digits are always shown.
  - Out-of-range bay_sel: digits are always blanked.
- Scan:
  - The 2-bit index advances every SCAN_DIV clocks, order 0→3 = thousands, hundreds, tens, ones.
  - an = one-hot-low for the current digit (0111, 1011, 1101, 1110), registered.
  - led_seg holds the pattern of the digit driven in that slot.
  - When blanked, an = 4'hF and led_seg holds its last value.
- Segment patterns (active low, abcdefg):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - codes 10–15 = 1111111
- Reset mid-operation: all bays are cleared regardless of any pending pulses or tick in that cycle.

Decomposition:
- Package `parking_pkg`:
  - display-state enum {DS_IDLE, DS_LOW, DS_HIGH, DS_OFF}
  - the 7-segment pattern function
  - a clog2 helper
  - default coin/preset constants
- Sub-module `parking_seg_scan`:
  - inputs: clk, rst, 16-bit BCD, blank
  - outputs: led_seg, an
  - owns the scan counter and SCAN_DIV divider
- The top level owns the prescaler, the per-bay count array, the priority mux, the BCD conversion (divide/modulo by 10, 100, 1000 on CNT_W bits) and the flags.

Test Plan:
- Default parameters:
  - Reset, then bay_sel=2, add[3] pulse → count[2]=300; after 1 cycle val=16'h0300; low_time[2]=0; expired=4'b1011.
  - Bay 1 at 9900, add[0] → count[1]=9960; add[2] → 9999 (saturates); a further add[3] stays at 9999.
  - bay_sel=0: preset_lo and add[3] in the same cycle → count[0]=16; run 17 ticks → count[0]=0, expired[0]=1, no wrap on further ticks.
  - Bay 0=100 and bay 3=50, bay_sel=3, add[1] coincident with tick → count[3]=170 (no decrement) and count[0]=99.
- Display: bay with count 5, selected → an blanks exactly in odd-count seconds; at count 0, an is blanked for the second half (prescaler 50..99) of each second; at count 200, an scans 0111→1011→1101→1110 continuously.
- Reset mid-operation: assert rst while counts are nonzero and add[0] is pulsing → next cycle all counts=0, an=4'hF, led_seg=7'h7F, val=0.

Source files
------------

// File: rtl/multi_bay_parking_meter_pkg.sv
// Shared types, defaults and helpers for the multi-bay parking meter.
// Imported by the interface, the display scanner and the top level.
package parking_pkg;

  typedef enum logic [1:0] {DS_IDLE, DS_LOW, DS_HIGH, DS_OFF} disp_state_t;

  localparam int DEF_ADD0      = 60;
  localparam int DEF_ADD1      = 120;
  localparam int DEF_ADD2      = 180;
  localparam int DEF_ADD3      = 300;
  localparam int DEF_PRESET_LO = 16;
  localparam int DEF_PRESET_HI = 150;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Active-low abcdefg; codes above 9 blank every segment.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] p;
    case (digit)
      4'd0:    p = 7'b0000001;
      4'd1:    p = 7'b1001111;
      4'd2:    p = 7'b0010010;
      4'd3:    p = 7'b0000110;
      4'd4:    p = 7'b1001100;
      4'd5:    p = 7'b0100100;
      4'd6:    p = 7'b0100000;
      4'd7:    p = 7'b0001111;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0000100;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/multi_bay_parking_meter_if.sv
// Bay-select / coin / preset inputs and display / status outputs of the meter.
// The meter is the slave; whatever drives coins and reads the display is the master.
interface multi_bay_parking_meter_if #(parameter int NUM_BAYS = 4);
  import parking_pkg::*;

  localparam int SEL_W = (clog2_f(NUM_BAYS) < 1) ? 1 : clog2_f(NUM_BAYS);

  logic [SEL_W-1:0]    bay_sel;
  logic [3:0]          add;
  logic                preset_lo;
  logic                preset_hi;
  logic [15:0]         val;
  logic [6:0]          led_seg;
  logic [3:0]          an;
  logic [NUM_BAYS-1:0] expired;
  logic [NUM_BAYS-1:0] low_time;

  modport master (
    output bay_sel, add, preset_lo, preset_hi,
    input  val, led_seg, an, expired, low_time
  );

  modport slave (
    input  bay_sel, add, preset_lo, preset_hi,
    output val, led_seg, an, expired, low_time
  );

endinterface

// File: rtl/multi_bay_parking_meter_seg_scan.sv
// Multiplexed 4-digit 7-segment driver: walks thousands..ones every SCAN_DIV clocks.
// While blanked the anodes are all off and the segment register keeps its last pattern.
module parking_seg_scan
  import parking_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        blank,
  output logic [6:0]  led_seg,
  output logic [3:0]  an
);

  localparam int DIV_W = (clog2_f(SCAN_DIV) < 1) ? 1 : clog2_f(SCAN_DIV);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       digit;

  always_comb begin
    digit = bcd[3:0];
    case (idx)
      2'd0:    digit = bcd[15:12];
      2'd1:    digit = bcd[11:8];
      2'd2:    digit = bcd[7:4];
      default: digit = bcd[3:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      idx     <= 2'd0;
      an      <= 4'hF;
      led_seg <= 7'h7F;
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (blank) begin
        an <= 4'hF;
      end else begin
        an      <= ~(4'b1000 >> idx);
        led_seg <= seg_pattern(digit);
      end
    end
  end

endmodule

// File: rtl/multi_bay_parking_meter.sv
// Multi-bay parking meter: per-bay second countdowns on a shared free-running tick,
// coin/preset actions on the selected bay, BCD readout and blinking display.
module multi_bay_parking_meter
  import parking_pkg::*;
#(
  parameter int CLK_HZ     = 100,
  parameter int NUM_BAYS   = 4,
  parameter int MAX_TIME   = 9999,
  parameter int ADD0       = DEF_ADD0,
  parameter int ADD1       = DEF_ADD1,
  parameter int ADD2       = DEF_ADD2,
  parameter int ADD3       = DEF_ADD3,
  parameter int PRESET_LO  = DEF_PRESET_LO,
  parameter int PRESET_HI  = DEF_PRESET_HI,
  parameter int LOW_THRESH = 180,
  parameter int SCAN_DIV   = 1
) (
  input logic clk,
  input logic rst,
  multi_bay_parking_meter_if.slave bus
);

  localparam int CNT_W = clog2_f(MAX_TIME + 1);
  localparam int PRE_W = (clog2_f(CLK_HZ) < 1) ? 1 : clog2_f(CLK_HZ);

  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [CNT_W-1:0] count [NUM_BAYS];
  logic             sel_valid;
  logic [CNT_W-1:0] sel_cnt;
  logic             act;
  logic [CNT_W-1:0] act_val;
  logic [CNT_W-1:0] add_amt;
  logic [CNT_W:0]   sum;
  logic [15:0]      bcd_next;
  logic [CNT_W-1:0] disp_cnt;
  logic             disp_valid;
  disp_state_t      disp_state;
  logic             blank;

  // Never cleared by coin activity, so one bay's coin cannot stretch the others' seconds.
  assign tick = (presc == PRE_W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  assign sel_valid = (32'(bus.bay_sel) < NUM_BAYS);

  always_comb begin
    sel_cnt = '0;
    act     = 1'b0;
    act_val = '0;
    add_amt = '0;
    sum     = '0;
    if (sel_valid) sel_cnt = count[bus.bay_sel];
    if (bus.preset_lo) begin
      act     = 1'b1;
      act_val = CNT_W'(PRESET_LO);
    end else if (bus.preset_hi) begin
      act     = 1'b1;
      act_val = CNT_W'(PRESET_HI);
    end else if (|bus.add) begin
      act = 1'b1;
      if (bus.add[3])      add_amt = CNT_W'(ADD3);
      else if (bus.add[2]) add_amt = CNT_W'(ADD2);
      else if (bus.add[1]) add_amt = CNT_W'(ADD1);
      else                 add_amt = CNT_W'(ADD0);
      sum     = {1'b0, sel_cnt} + {1'b0, add_amt};
      act_val = (sum > (CNT_W + 1)'(MAX_TIME)) ? CNT_W'(MAX_TIME) : sum[CNT_W-1:0];
    end
    if (!sel_valid) act = 1'b0;
  end

  // A written bay skips the decrement of a coincident tick; the other bays still count down.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BAYS; i++) begin
      if (rst)                                     count[i] <= '0;
      else if (act && int'(bus.bay_sel) == i)      count[i] <= act_val;
      else if (tick && count[i] != '0)             count[i] <= count[i] - 1'b1;
    end
  end

  always_comb begin
    bus.expired  = '0;
    bus.low_time = '0;
    for (int i = 0; i < NUM_BAYS; i++) begin
      bus.expired[i]  = (count[i] == '0);
      bus.low_time[i] = (count[i] != '0) && (32'(count[i]) < LOW_THRESH);
    end
  end

  always_comb begin
    int unsigned c;
    c        = 32'(sel_cnt);
    bcd_next = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.val    <= '0;
      disp_cnt   <= '0;
      disp_valid <= 1'b0;
    end else begin
      bus.val    <= bcd_next;
      disp_cnt   <= sel_cnt;
      disp_valid <= sel_valid;
    end
  end

  // Blink mode follows the same registered count that feeds val.
  always_comb begin
    disp_state = DS_OFF;
    blank      = 1'b1;
    if (disp_valid) begin
      if (disp_cnt == '0)                   disp_state = DS_IDLE;
      else if (32'(disp_cnt) < LOW_THRESH)  disp_state = DS_LOW;
      else                                  disp_state = DS_HIGH;
    end
    case (disp_state)
      DS_IDLE: blank = (32'(presc) >= CLK_HZ / 2);
      DS_LOW:  blank = disp_cnt[0];
      DS_HIGH: blank = 1'b0;
      default: blank = 1'b1;
    endcase
  end

  parking_seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .bcd     (bus.val),
    .blank   (blank),
    .led_seg (bus.led_seg),
    .an      (bus.an)
  );

endmodule

// File: tb/tb_multi_bay_parking_meter.sv
// Directed bench for multi_bay_parking_meter: a table of single-action vectors plus
// hand-written sequences for saturation, tick coincidence, countdown blink and reset.
module tb_multi_bay_parking_meter;

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  add;
      logic        plo;
      logic        phi;
      logic [15:0] exp_val;
      logic [3:0]  exp_expired;
      logic [3:0]  exp_low;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   vec_t vecs [10];

   multi_bay_parking_meter_if #(.NUM_BAYS(4)) bus ();

   multi_bay_parking_meter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      bus.add       = 4'b0000;
      bus.preset_lo = 1'b0;
      bus.preset_hi = 1'b0;
   endtask

   task automatic doReset();
      clearInputs();
      bus.bay_sel = 2'd0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Pulse one action for a cycle, then give val one more cycle to follow.
   task automatic applyStimulus(input vec_t v, input string name);
      bus.bay_sel   = v.sel;
      bus.add       = v.add;
      bus.preset_lo = v.plo;
      bus.preset_hi = v.phi;
      step();
      clearInputs();
      step();
      checkOutput({name, ".val"}, 32'(bus.val), 32'(v.exp_val));
      checkOutput({name, ".expired"}, 32'(bus.expired), 32'(v.exp_expired));
      checkOutput({name, ".low_time"}, 32'(bus.low_time), 32'(v.exp_low));
   endtask

   function automatic logic [15:0] toBcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [6:0] segOf(input logic [3:0] d);
      logic [6:0] t [10];
      t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
      return t[d];
   endfunction

   initial begin
      logic [3:0] prev_an;
      int bad_a, bad_b, bad_scan, c;
      logic exp_a, exp_b;

      vecs[0] = '{2'd2, 4'b1000, 1'b0, 1'b0, 16'h0300, 4'b1011, 4'b0000};
      vecs[1] = '{2'd1, 4'b0000, 1'b0, 1'b1, 16'h0150, 4'b1001, 4'b0010};
      vecs[2] = '{2'd1, 4'b0001, 1'b0, 1'b0, 16'h0210, 4'b1001, 4'b0000};
      vecs[3] = '{2'd0, 4'b1000, 1'b1, 1'b0, 16'h0016, 4'b1000, 4'b0001};
      vecs[4] = '{2'd3, 4'b0011, 1'b0, 1'b0, 16'h0120, 4'b0000, 4'b1001};
      vecs[5] = '{2'd3, 4'b0000, 1'b1, 1'b1, 16'h0016, 4'b0000, 4'b1001};
      vecs[6] = '{2'd2, 4'b0110, 1'b0, 1'b0, 16'h0480, 4'b0000, 4'b1001};
      vecs[7] = '{2'd0, 4'b0000, 1'b0, 1'b0, 16'h0016, 4'b0000, 4'b1001};
      vecs[8] = '{2'd1, 4'b1000, 1'b0, 1'b1, 16'h0150, 4'b0000, 4'b1011};
      vecs[9] = '{2'd1, 4'b0010, 1'b0, 1'b0, 16'h0270, 4'b0000, 4'b1001};

      $display("[TB] start");
      doReset();
      checkOutput("reset.val", 32'(bus.val), 32'h0);
      checkOutput("reset.an", 32'(bus.an), 32'hF);
      checkOutput("reset.led_seg", 32'(bus.led_seg), 32'h7F);
      checkOutput("reset.expired", 32'(bus.expired), 32'hF);
      checkOutput("reset.low_time", 32'(bus.low_time), 32'h0);

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // Saturation: 33 coins of 300 on bay 1, then top up past MAX_TIME.
      doReset();
      bus.bay_sel = 2'd1;
      bus.add = 4'b1000;
      for (int i = 0; i < 33; i++) step();
      clearInputs();
      step();
      checkOutput("sat.base", 32'(bus.val), 32'h9900);
      applyStimulus('{2'd1, 4'b0001, 1'b0, 1'b0, 16'h9960, 4'b1101, 4'b0000}, "sat.add0");
      applyStimulus('{2'd1, 4'b0100, 1'b0, 1'b0, 16'h9999, 4'b1101, 4'b0000}, "sat.add2");
      applyStimulus('{2'd1, 4'b1000, 1'b0, 1'b0, 16'h9999, 4'b1101, 4'b0000}, "sat.add3");

      // Coin coincident with tick: bay 3 skips that decrement, bay 0 does not.
      doReset();
      applyStimulus('{2'd0, 4'b0010, 1'b0, 1'b0, 16'h0120, 4'b1110, 4'b0001}, "tk.bay0");
      applyStimulus('{2'd3, 4'b0001, 1'b0, 1'b0, 16'h0060, 4'b0110, 4'b1001}, "tk.bay3");
      while (cyc % 100 != 99) step();
      bus.add = 4'b0010;
      step();
      clearInputs();
      checkOutput("tk.expired", 32'(bus.expired), 32'b0110);
      checkOutput("tk.low_time", 32'(bus.low_time), 32'b0001);
      step();
      checkOutput("tk.val3", 32'(bus.val), 32'h0180);
      bus.bay_sel = 2'd0;
      step();
      checkOutput("tk.val0", 32'(bus.val), 32'h0119);

      // High count: continuous scan with the right digit in each slot.
      doReset();
      bus.bay_sel = 2'd2;
      bus.add = 4'b1000;
      step();
      clearInputs();
      step();
      step();
      step();
      bad_scan = 0;
      prev_an = bus.an;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.an != {prev_an[0], prev_an[3:1]}) bad_scan++;
         case (bus.an)
            4'b0111: if (bus.led_seg != segOf(4'd0)) bad_scan++;
            4'b1011: if (bus.led_seg != segOf(4'd3)) bad_scan++;
            4'b1101: if (bus.led_seg != segOf(4'd0)) bad_scan++;
            4'b1110: if (bus.led_seg != segOf(4'd0)) bad_scan++;
            default: bad_scan++;
         endcase
         prev_an = bus.an;
      end
      checkOutput("scan.high", 32'(bad_scan), 32'd0);

      // Countdown from 16 on bay 0 through LOW blink, IDLE blink and no wrap.
      doReset();
      bus.bay_sel = 2'd0;
      bus.preset_lo = 1'b1;
      bus.add = 4'b1000;
      step();
      clearInputs();
      bad_a = 0;
      bad_b = 0;
      while (cyc < 2000) begin
         step();
         c = 16 - cyc / 100;
         if (c < 0) c = 0;
         exp_a = (c != 0) && (c % 2 == 1);
         exp_b = (c == 0) || (c % 2 == 1);
         case (cyc % 100)
            0: begin bad_a = 0; bad_b = 0; end
            5: begin
               checkOutput($sformatf("cd%0d.val", c), 32'(bus.val), 32'(toBcd(c)));
               checkOutput($sformatf("cd%0d.expired", c), 32'(bus.expired[0]), 32'(c == 0));
               checkOutput($sformatf("cd%0d.low", c), 32'(bus.low_time[0]), 32'(c != 0));
            end
            46: checkOutput($sformatf("cd%0d.blink_first_half", c), 32'(bad_a), 32'd0);
            96: checkOutput($sformatf("cd%0d.blink_second_half", c), 32'(bad_b), 32'd0);
            default: ;
         endcase
         if (cyc % 100 >= 5 && cyc % 100 <= 45 && ((bus.an == 4'hF) != exp_a)) bad_a++;
         if (cyc % 100 >= 55 && cyc % 100 <= 95 && ((bus.an == 4'hF) != exp_b)) bad_b++;
      end

      // Reset while counts are nonzero and a coin is pulsing.
      doReset();
      applyStimulus('{2'd2, 4'b1000, 1'b0, 1'b0, 16'h0300, 4'b1011, 4'b0000}, "mr.bay2");
      applyStimulus('{2'd1, 4'b0001, 1'b0, 1'b0, 16'h0060, 4'b1001, 4'b0010}, "mr.bay1");
      step();
      step();
      bus.add = 4'b0001;
      rst = 1'b1;
      step();
      checkOutput("mr.val", 32'(bus.val), 32'h0);
      checkOutput("mr.an", 32'(bus.an), 32'hF);
      checkOutput("mr.led_seg", 32'(bus.led_seg), 32'h7F);
      checkOutput("mr.expired", 32'(bus.expired), 32'hF);
      checkOutput("mr.low_time", 32'(bus.low_time), 32'h0);
      rst = 1'b0;
      clearInputs();
      step();
      checkOutput("mr.after_expired", 32'(bus.expired), 32'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
